// File: rtl/psone_pad_responder.sv
// psone_pad_responder: digital-pad side of the PlayStation ATT/CLK/CMD/DAT/ACK link
module psone_pad_responder #(
  parameter logic [7:0] PAD_ID  = 8'h41,
  parameter int         ACK_DLY = 100,
  parameter int         ACK_LEN = 100
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iCS,
  input  logic        iSCK,
  input  logic        iMOSI,
  input  logic [15:0] iBUTTONS,
  output logic        oMISO,
  output logic        oACK,
  output logic        oFRAME_DONE,
  output logic        oERR
);
  localparam int TW = $clog2((ACK_DLY > ACK_LEN ? ACK_DLY : ACK_LEN) + 1);
  localparam logic [TW-1:0] DLY_END = TW'(ACK_DLY - 1);
  localparam logic [TW-1:0] LEN_END = TW'(ACK_LEN - 1);
  typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_LOW, IGNORE} state_t;
  state_t state, state_n;
  logic [1:0] cs_s, sck_s, mosi_s;
  logic cs_d, sck_d;
  logic [2:0] byte_cnt, byte_n, bit_cnt, bit_n;
  logic [7:0] rx, rx_n, tx, tx_n, rx_full, tx_next;
  logic [15:0] snap, snap_n;
  logic [TW-1:0] timer, timer_n;
  logic miso, miso_n, ack, ack_n, done, done_n, err, err_n;
  logic cs_fall, cs_rise, sck_fall, sck_rise, active, bad;
  // synchronizers are left unreset so a CS held low through reset never looks like a fresh falling edge
  always_ff @(posedge iCLK) begin
    cs_s   <= {cs_s[0], iCS};
    sck_s  <= {sck_s[0], iSCK};
    mosi_s <= {mosi_s[0], iMOSI};
    cs_d   <= cs_s[1];
    sck_d  <= sck_s[1];
  end
  assign cs_fall  = cs_d & ~cs_s[1];
  assign cs_rise  = ~cs_d & cs_s[1];
  assign sck_fall = sck_d & ~sck_s[1];
  assign sck_rise = ~sck_d & sck_s[1];
  assign active   = (state == SHIFT) || (state == ACK_WAIT) || (state == ACK_LOW);
  assign rx_full  = {mosi_s[1], rx[7:1]};
  assign bad      = (byte_cnt == 3'd0 && rx_full != 8'h01) || (byte_cnt == 3'd1 && rx_full != 8'h42);
  assign tx_next  = byte_cnt == 3'd0 ? PAD_ID : byte_cnt == 3'd1 ? 8'h5A :
                    byte_cnt == 3'd2 ? snap[7:0] : snap[15:8];
  // state and datapath register
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state    <= IDLE;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      rx       <= '0;
      tx       <= '0;
      snap     <= 16'hFFFF;
      timer    <= '0;
      miso     <= 1'b1;
      ack      <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_n;
      bit_cnt  <= bit_n;
      rx       <= rx_n;
      tx       <= tx_n;
      snap     <= snap_n;
      timer    <= timer_n;
      miso     <= miso_n;
      ack      <= ack_n;
      done     <= done_n;
      err      <= err_n;
    end
  end
  // next state: CS rise has priority, ACK timing runs alongside bit shifting of the following byte
  always_comb begin
    state_n = state;
    byte_n  = byte_cnt;
    bit_n   = bit_cnt;
    rx_n    = rx;
    tx_n    = tx;
    snap_n  = snap;
    timer_n = timer;
    miso_n  = miso;
    ack_n   = ack;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (cs_rise) begin
      state_n = IDLE;
      byte_n  = '0;
      bit_n   = '0;
      timer_n = '0;
      miso_n  = 1'b1;
      ack_n   = 1'b1;
    end else begin
      case (state)
        IDLE: if (cs_fall) begin
          state_n = SHIFT;
          snap_n  = ~iBUTTONS;
          byte_n  = '0;
          bit_n   = '0;
          tx_n    = 8'hFF;
          miso_n  = 1'b1;
        end
        ACK_WAIT: begin
          timer_n = timer + TW'(1);
          if (timer == DLY_END) begin
            state_n = ACK_LOW;
            timer_n = '0;
            ack_n   = 1'b0;
          end
        end
        ACK_LOW: begin
          timer_n = timer + TW'(1);
          if (timer == LEN_END) begin
            state_n = SHIFT;
            timer_n = '0;
            ack_n   = 1'b1;
          end
        end
        default: ;
      endcase
      if (active && sck_fall) miso_n = tx[bit_cnt];
      if (active && sck_rise) begin
        rx_n  = rx_full;
        bit_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_n  = byte_cnt + 3'd1;
          timer_n = '0;
          ack_n   = 1'b1;
          if (bad || byte_cnt >= 3'd4) begin
            state_n = IGNORE;
            miso_n  = 1'b1;
            err_n   = bad;
            done_n  = ~bad;
          end else begin
            state_n = ACK_WAIT;
            tx_n    = tx_next;
            miso_n  = tx_next[0];
          end
        end
      end
    end
  end
  assign oMISO       = miso;
  assign oACK        = ack;
  assign oFRAME_DONE = done;
  assign oERR        = err;
endmodule
